// File: rtl/quick_spi_slave_pkg.sv
// Shared definitions for the quick_spi master/slave pair: order encodings,
// FSM states and the wire-bit to word-bit mapping used on both sides.
package quick_spi_pkg;

    localparam int LITTLE_ENDIAN = 0;
    localparam int BIG_ENDIAN    = 1;
    localparam int LSB_FIRST     = 0;
    localparam int MSB_FIRST     = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // Word bit position carried by wire bit k of a frame word.
    function automatic int wire_bit_index(input int k, input int nbytes,
                                          input int bytes_order, input int bits_order);
        int byte_idx;
        int bit_idx;
        byte_idx = (bytes_order == BIG_ENDIAN) ? (nbytes - 1 - k / 8) : (k / 8);
        bit_idx  = (bits_order == MSB_FIRST) ? (7 - k % 8) : (k % 8);
        return byte_idx * 8 + bit_idx;
    endfunction

endpackage

// File: rtl/quick_spi_slave_if.sv
// SPI pin bundle shared by the quick_spi master and slave.
interface quick_spi_if;
    logic sclk;
    logic mosi;
    logic ss_n;
    logic miso;

    modport master (output sclk, output mosi, output ss_n, input miso);
    modport slave  (input sclk, input mosi, input ss_n, output miso);
endinterface

// File: rtl/quick_spi_slave_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered history for
// rise/fall detection on the synchronized copy.
module quick_spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/quick_spi_slave.sv
// SPI slave oversampling sclk/mosi/ss_n in the clk domain; back-to-back words.
// Optional QUICK_SPI_SLAVE_MISO_TRISTATE_EN floats miso outside an active frame.
module quick_spi_slave
    import quick_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int BYTES_ORDER = LITTLE_ENDIAN,
    parameter int BITS_ORDER  = LSB_FIRST
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ack,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy,
    quick_spi_if.slave            spi
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_meta, mosi_s;

    quick_spi_sync_edge #(.RESET_VAL(CPOL != 0)) u_sclk_sync (
        .clk(clk), .reset_n(reset_n), .din(spi.sclk),
        .dout(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    quick_spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .reset_n(reset_n), .din(spi.ss_n),
        .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= spi.mosi;
            mosi_s    <= mosi_meta;
        end
    end

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    spi_state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_shift, rx_shift;
    logic [IDX_W-1:0] bit_cnt, tx_idx, tx_pos, rx_pos;
    logic start, sample, shift, last_bit, abort, word_done, reload;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // An ss_n rise coinciding with the final sample still completes the word.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        sample   = 1'b0;
        shift    = 1'b0;
        last_bit = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_fall && enable) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                last_bit = sample_edge && (bit_cnt == LAST_BIT);
                sample   = sample_edge && (!ss_rise || last_bit);
                shift    = shift_edge && !ss_rise;
                if (ss_rise) begin
                    state_d = IDLE;
                    abort   = !last_bit && (bit_cnt != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign reload = word_done && (state_q == ACTIVE);
    assign rx_pos = IDX_W'(wire_bit_index(int'(bit_cnt), NBYTES, BYTES_ORDER, BITS_ORDER));
    assign tx_pos = IDX_W'(wire_bit_index(int'(tx_idx), NBYTES, BYTES_ORDER, BITS_ORDER));

    // The shift edge presents the wire bit equal to the number of samples taken so far.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            bit_cnt     <= '0;
            tx_idx      <= '0;
            word_done   <= 1'b0;
            rx_valid    <= 1'b0;
            tx_ack      <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            word_done   <= last_bit;
            rx_valid    <= word_done;
            tx_ack      <= start | reload;
            frame_error <= abort;
            if (word_done)      rx_data  <= rx_shift;
            if (start | reload) tx_shift <= tx_data;
            if (start)          tx_idx   <= '0;
            else if (shift)     tx_idx   <= bit_cnt;
            if (start) begin
                bit_cnt <= '0;
            end else if (sample) begin
                rx_shift[rx_pos] <= mosi_s;
                bit_cnt          <= last_bit ? '0 : bit_cnt + IDX_W'(1);
            end
        end
    end

    assign busy = (state_q == ACTIVE) && !ss_s;

`ifdef QUICK_SPI_SLAVE_MISO_TRISTATE_EN
    assign spi.miso = (state_q == ACTIVE) ? tx_shift[tx_pos] : 1'bz;
`else
    assign spi.miso = (state_q == ACTIVE) ? tx_shift[tx_pos] : 1'b0;
`endif

endmodule

// File: tb/tb_quick_spi_slave.sv
// Bench for quick_spi_slave: a mode-0 LE/LSB slave and a mode-3 BE/MSB slave
// driven by a behavioural master, checked against a byte-list wire model.
module tb_quick_spi_slave;

    localparam int DW = 16;
    localparam int H  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          en       [2];
    logic [DW-1:0] tx_in    [2];
    logic          tx_ack_w [2];
    logic [DW-1:0] rx_w     [2];
    logic          rxv_w    [2];
    logic          ferr_w   [2];
    logic          busy_w   [2];

    logic sclk_m, mosi_m, ss_m;
    int   sel;

    quick_spi_if ifa ();
    quick_spi_if ifb ();

    assign ifa.sclk = (sel == 0) ? sclk_m : 1'b0;
    assign ifa.ss_n = (sel == 0) ? ss_m : 1'b1;
    assign ifa.mosi = mosi_m;
    assign ifb.sclk = (sel == 1) ? ~sclk_m : 1'b1;
    assign ifb.ss_n = (sel == 1) ? ss_m : 1'b1;
    assign ifb.mosi = mosi_m;

    quick_spi_slave #(.DATA_WIDTH(DW), .CPOL(0), .CPHA(0), .BYTES_ORDER(0), .BITS_ORDER(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en[0]), .tx_data(tx_in[0]),
        .tx_ack(tx_ack_w[0]), .rx_data(rx_w[0]), .rx_valid(rxv_w[0]),
        .frame_error(ferr_w[0]), .busy(busy_w[0]), .spi(ifa)
    );

    quick_spi_slave #(.DATA_WIDTH(DW), .CPOL(1), .CPHA(1), .BYTES_ORDER(1), .BITS_ORDER(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en[1]), .tx_data(tx_in[1]),
        .tx_ack(tx_ack_w[1]), .rx_data(rx_w[1]), .rx_valid(rxv_w[1]),
        .frame_error(ferr_w[1]), .busy(busy_w[1]), .spi(ifb)
    );

    int checks   = 0;
    int failures = 0;

    int rxv_cnt  [2];
    int ack_cnt  [2];
    int ferr_cnt [2];
    logic [DW-1:0] rx_log_a [$];
    logic [DW-1:0] rx_log_b [$];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rxv_cnt[d]  = 0;
            ack_cnt[d]  = 0;
            ferr_cnt[d] = 0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rxv_w[d] === 1'b1)    rxv_cnt[d]++;
            if (tx_ack_w[d] === 1'b1) ack_cnt[d]++;
            if (ferr_w[d] === 1'b1)   ferr_cnt[d]++;
        end
        if (rxv_w[0] === 1'b1) rx_log_a.push_back(rx_w[0]);
        if (rxv_w[1] === 1'b1) rx_log_b.push_back(rx_w[1]);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rx_at(input int d, input int idx);
        if (d == 0) return (idx < rx_log_a.size()) ? rx_log_a[idx] : 'x;
        return (idx < rx_log_b.size()) ? rx_log_b[idx] : 'x;
    endfunction

    // Wire order model: list the bytes in transmit order, then walk each byte's bits.
    // Bit k of the result is the k-th bit on the wire. d=1 is the BE/MSB slave.
    function automatic logic [DW-1:0] wire_stream(input logic [DW-1:0] w, input int d);
        logic [7:0]    seq [$];
        logic [7:0]    by;
        logic [DW-1:0] s;
        int            k;
        s = '0;
        k = 0;
        for (int b = 0; b < DW / 8; b++) begin
            if (d == 1) seq.push_front(w[b*8 +: 8]);
            else        seq.push_back(w[b*8 +: 8]);
        end
        foreach (seq[i]) begin
            by = seq[i];
            for (int j = 0; j < 8; j++) begin
                s[k] = (d == 1) ? by[7-j] : by[j];
                k++;
            end
        end
        return s;
    endfunction

    logic [DW-1:0] mw [4];
    logic [DW-1:0] tw [4];
    logic [63:0]   mcap;
    logic          busy_mid;
    logic [DW-1:0] last_rx_exp [2];

    function automatic logic cur_miso(input int d);
        return (d == 0) ? ifa.miso : ifb.miso;
    endfunction

    // d=0: mode 0 master; d=1: mode 3 master (logical sclk inverted onto the pin).
    task automatic run_frame(input int d, input int nwords, input int nbits,
                             input bit hold, input bit early_ss);
        logic [DW-1:0] s;
        int w, k;
        sel      = d;
        tx_in[d] = tw[0];
        mcap     = '0;
        busy_mid = 1'b0;
        wait_clk(4);
        ss_m = 1'b0;
        if (d == 1) wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            w = i / DW;
            k = i % DW;
            s = wire_stream(mw[w], d);
            if (d == 0) begin
                mosi_m = s[k];
                wait_clk(H);
                mcap[i] = cur_miso(d);
                if (i == 0) busy_mid = busy_w[d];
                sclk_m = 1'b1;
                if (k == DW - 1) tx_in[d] = tw[w+1];
                wait_clk(H);
                sclk_m = 1'b0;
            end else begin
                sclk_m = 1'b1;
                mosi_m = s[k];
                wait_clk(H);
                mcap[i] = cur_miso(d);
                if (i == 0) busy_mid = busy_w[d];
                sclk_m = 1'b0;
                if (early_ss && i == nbits - 1) ss_m = 1'b1;
                if (k == DW - 1) tx_in[d] = tw[w+1];
                wait_clk(H);
            end
        end
        if (d == 0) wait_clk(H);
        if (!hold) begin
            ss_m = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic frame_and_check(input string tag, input int d, input int nwords);
        int r0, a0, f0;
        logic [63:0] exp;
        r0 = rxv_cnt[d];
        a0 = ack_cnt[d];
        f0 = ferr_cnt[d];
        run_frame(d, nwords, nwords * DW, 1'b0, 1'b0);
        chk({tag, "_rxcnt"}, 64'(rxv_cnt[d] - r0), 64'(nwords));
        for (int w = 0; w < nwords; w++)
            chk({tag, "_rxword"}, 64'(rx_at(d, r0 + w)), 64'(mw[w]));
        chk({tag, "_txack"}, 64'(ack_cnt[d] - a0), 64'(nwords + 1));
        chk({tag, "_ferr"}, 64'(ferr_cnt[d] - f0), 64'd0);
        exp = '0;
        for (int w = 0; w < nwords; w++) exp[w*DW +: DW] = wire_stream(tw[w], d);
        chk({tag, "_miso"}, mcap, exp);
        chk({tag, "_busy"}, 64'(busy_mid), 64'd1);
        last_rx_exp[d] = mw[nwords-1];
    endtask

    typedef struct {
        int            d;
        logic [DW-1:0] mword;
        logic [DW-1:0] tword;
        logic [DW-1:0] exp_rx;
        logic [DW-1:0] exp_miso;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int r0, a0, f0;

        vecs[0] = '{0, 16'hCC82, 16'h2B95, 16'hCC82, 16'h2B95};
        vecs[1] = '{1, 16'hA55A, 16'h1234, 16'hA55A, 16'h2C48};
        vecs[2] = '{0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[3] = '{1, 16'h0001, 16'h8000, 16'h0001, 16'h0001};
        vecs[4] = '{0, 16'h5A5A, 16'hA5A5, 16'h5A5A, 16'hA5A5};
        vecs[5] = '{1, 16'h00FF, 16'hFF00, 16'h00FF, 16'h00FF};

        sel = 0; sclk_m = 1'b0; ss_m = 1'b1; mosi_m = 1'b0;
        en[0] = 1'b1; en[1] = 1'b1;
        tx_in[0] = '0; tx_in[1] = '0;
        last_rx_exp[0] = '0; last_rx_exp[1] = '0;
        reset_n = 1'b0;
        wait_clk(3);
        for (int d = 0; d < 2; d++) begin
            chk("reset_rx_data", 64'(rx_w[d]), 64'd0);
            chk("reset_pulses", 64'({rxv_w[d], tx_ack_w[d], ferr_w[d]}), 64'd0);
            chk("reset_busy", 64'(busy_w[d]), 64'd0);
            chk("reset_miso", 64'(cur_miso(d)), 64'd0);
        end
        reset_n = 1'b1;
        wait_clk(3);

        for (int i = 0; i < 6; i++) begin
            mw[0] = vecs[i].mword;
            tw[0] = vecs[i].tword;
            tw[1] = vecs[i].tword;
            frame_and_check("vec", vecs[i].d, 1);
            chk("vec_rx_const", 64'(rx_w[vecs[i].d]), 64'(vecs[i].exp_rx));
            chk("vec_miso_const", 64'(mcap[DW-1:0]), 64'(vecs[i].exp_miso));
        end

        mw[0] = 16'h0001; mw[1] = 16'h8000;
        tw[0] = 16'h1111; tw[1] = 16'h2222; tw[2] = 16'h3333;
        frame_and_check("b2b_a", 0, 2);
        frame_and_check("b2b_b", 1, 2);

        for (int r = 0; r < 16; r++) begin
            int d, n;
            d = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            for (int w = 0; w < 4; w++) begin
                mw[w] = DW'($urandom);
                tw[w] = DW'($urandom);
            end
            frame_and_check("rand", d, n);
        end

        for (int d = 0; d < 2; d++) begin
            r0 = rxv_cnt[d]; a0 = ack_cnt[d]; f0 = ferr_cnt[d];
            mw[0] = 16'hDEAD; tw[0] = 16'hBEEF; tw[1] = 16'hBEEF;
            run_frame(d, 1, 9, 1'b0, 1'b0);
            chk("abort_ferr", 64'(ferr_cnt[d] - f0), 64'd1);
            chk("abort_rxcnt", 64'(rxv_cnt[d] - r0), 64'd0);
            chk("abort_rx_kept", 64'(rx_w[d]), 64'(last_rx_exp[d]));
            chk("abort_busy", 64'(busy_w[d]), 64'd0);
            chk("abort_ack", 64'(ack_cnt[d] - a0), 64'd1);
            mw[0] = 16'h0F0F; tw[0] = 16'h3C3C; tw[1] = 16'h3C3C;
            frame_and_check("after_abort", d, 1);
        end

        r0 = rxv_cnt[1]; f0 = ferr_cnt[1];
        mw[0] = 16'h7E81; tw[0] = 16'h4242; tw[1] = 16'h4242;
        run_frame(1, 1, DW, 1'b1, 1'b1);
        wait_clk(8);
        chk("simul_rxcnt", 64'(rxv_cnt[1] - r0), 64'd1);
        chk("simul_ferr", 64'(ferr_cnt[1] - f0), 64'd0);
        chk("simul_rx", 64'(rx_w[1]), 64'h7E81);
        chk("simul_busy", 64'(busy_w[1]), 64'd0);
        last_rx_exp[1] = 16'h7E81;

        en[0] = 1'b0;
        r0 = rxv_cnt[0]; a0 = ack_cnt[0];
        mw[0] = 16'h1357; tw[0] = 16'hFFFF; tw[1] = 16'hFFFF;
        run_frame(0, 1, DW, 1'b0, 1'b0);
        chk("disabled_rxcnt", 64'(rxv_cnt[0] - r0), 64'd0);
        chk("disabled_ack", 64'(ack_cnt[0] - a0), 64'd0);
        chk("disabled_miso", mcap, 64'd0);
        chk("disabled_busy", 64'(busy_mid), 64'd0);
        chk("disabled_rx_kept", 64'(rx_w[0]), 64'(last_rx_exp[0]));
        en[0] = 1'b1;

        mw[0] = 16'hC001; tw[0] = 16'hFFFF; tw[1] = 16'hFFFF;
        run_frame(0, 1, 5, 1'b1, 1'b0);
        chk("pre_reset_busy", 64'(busy_w[0]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset_rx_data", 64'(rx_w[0]), 64'd0);
        chk("midreset_pulses", 64'({rxv_w[0], tx_ack_w[0], ferr_w[0]}), 64'd0);
        chk("midreset_busy", 64'(busy_w[0]), 64'd0);
        chk("midreset_miso", 64'(ifa.miso), 64'd0);
        ss_m = 1'b1;
        sclk_m = 1'b0;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(4);
        last_rx_exp[0] = '0;
        mw[0] = 16'h00FF; tw[0] = 16'h6699; tw[1] = 16'h6699;
        frame_and_check("post_reset", 0, 1);
        chk("post_reset_rx", 64'(rx_w[0]), 64'h00FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
